sparc_window_regfile: RTL
=========================

# sparc_window_regfile

Parametrised SPARC V8 windowed integer register file with integrated current-window-pointer (CWP) management and window overflow/underflow detection. It succeeds the fixed 32-bit register file in the datapath: window count and data width are configurable, SAVE/RESTORE and WRPSR CWP writes are handled internally, and trap requests are raised against the window invalid mask (WIM). It sits between the IR-driven address muxes, the ALU result bus and the PSR/trap logic.

## Interface
- NWINDOWS, 8: number of register windows, 2..32.
- WIDTH, 32: data width in bits.
- CWPW, $clog2(NWINDOWS), minimum 1: width of the CWP.

- Clk  in  1  clock; all state changes on the rising edge.
- Clr_n  in  1  asynchronous active-low reset.
- SA, SB  in  5  read addresses for port A and port B, r0..r31.
- PA, PB  out  WIDTH  read data for port A and port B.
- SC  in  5  write address.
- PC  in  WIDTH  write data.
- Ld  in  1  write enable.
- save_req, restore_req  in  1  SAVE and RESTORE window operations.
- cwp_ld  in  1  load the CWP from cwp_in (WRPSR).
- cwp_in  in  5  new CWP value.
- wim  in  NWINDOWS  window invalid mask.
- cwp  out  CWPW  current window pointer; reset 0.
- wof_trap, wuf_trap, cwp_err  out  1  window overflow, window underflow and illegal-CWP pulses; each resets to 0.

## Operation
- Storage: 8 globals plus NWINDOWS×16 windowed registers.
- r0 reads as 0; writes to r0 are discarded.
- Address map for window w:
  - r1–r7: globals 1–7.
  - r8–r15: outs(w), physical 8+16w+0..7.
  - r16–r23: locals(w), physical 8+16w+8..15.
  - r24–r31: ins(w), equal to outs((w+1) mod NWINDOWS).
- Window operation priority: cwp_ld > save_req > restore_req. Lower-priority requests asserted in the same cycle are ignored.
- cwp_ld:
  - cwp_in < NWINDOWS: cwp ← cwp_in.
  - Otherwise: cwp unchanged, cwp_err pulses.
- save_req: candidate n = (cwp−1) mod NWINDOWS.
  - wim[n]=1: wof_trap pulses, cwp unchanged.
  - Otherwise: cwp ← n.
- restore_req: candidate n = (cwp+1) mod NWINDOWS.
  - wim[n]=1: wuf_trap pulses, cwp unchanged.
  - Otherwise: cwp ← n.
- Write window:
  - A write in the same cycle as a successful save or restore is decoded in the new window n. This matches SPARC, where SAVE/RESTORE write rd in the new window.
  - Otherwise the write is decoded in the current cwp.
- Write suppression: a write is suppressed in any cycle that raises wof_trap, wuf_trap or cwp_err.
- Wrap-around: cwp 0 with save goes to NWINDOWS−1; cwp NWINDOWS−1 with restore goes to 0.
- Reset:
  - cwp=0 and all pulse outputs cleared, immediately and asynchronously.
  - Register contents are not reset; reads before a write are undefined except r0.
  - Reset asserted mid-operation aborts any pending update on that edge.

## Timing
- Reads are combinational from SA/SB using the current cwp, 0-cycle latency.
- Writes and cwp updates take effect at the rising edge. The new value is visible on PA/PB and cwp in the following cycle.
- Trap and err pulses are registered: high for exactly one cycle after the edge that sampled the request.
- Back-to-back requests are accepted every cycle; there is no busy state.

## Configuration
- RF_BYPASS_EN defined:
  - If Ld=1, the write is not suppressed, and the write's physical index equals a read port's physical index (current cwp mapping), that port returns PC in the same cycle.
  - r0 is never bypassed.
- RF_BYPASS_EN undefined: read ports return stored contents only; the new value appears the next cycle.

## Test plan
- NWINDOWS=8, reset → cwp=0, PA for SA=0 reads 0.
  - Write r0=0xFFFFFFFF → PA for SA=0 still reads 0.
- cwp=0:
  - Write r8=0x11111111.
  - save_req with wim=0 → cwp=7.
  - r24 now reads 0x11111111.
  - restore_req → cwp=0, r8 reads 0x11111111.
- cwp=3, wim=8'b0000_0100, save_req → wof_trap high one cycle, cwp stays 3.
  - Simultaneous Ld to r16 is dropped; r16 keeps its prior value.
- cwp=7, wim=0, restore_req → cwp=0.
  - Same cycle, save_req and cwp_ld with cwp_in=9 → cwp_err pulses, cwp unchanged.
- save_req with Ld to r9=0xA5A5A5A5 at cwp=2 → value lands in outs(1).
  - Reads at cwp=1 give r9=0xA5A5A5A5.
  - Reads at cwp=2 give r9≠0xA5A5A5A5.
- Ld r5=0xDEADBEEF with SA=5 in the same cycle:
  - With RF_BYPASS_EN, PA=0xDEADBEEF that cycle.
  - Without it, PA shows the old value, then 0xDEADBEEF next cycle.
  - Assert Clr_n low mid-cycle → cwp=0 asynchronously.

Source files
------------

// File: rtl/sparc_window_regfile.sv
// SPARC V8 windowed register file with CWP management and window traps.
// Optional same-cycle write-to-read bypass: define RF_BYPASS_EN.
module sparc_window_regfile #(
    parameter int NWINDOWS = 8,
    parameter int WIDTH    = 32,
    parameter int CWPW     = (NWINDOWS > 2) ? $clog2(NWINDOWS) : 1
) (
    input  logic                Clk,
    input  logic                Clr_n,
    input  logic [4:0]          SA,
    input  logic [4:0]          SB,
    output logic [WIDTH-1:0]    PA,
    output logic [WIDTH-1:0]    PB,
    input  logic [4:0]          SC,
    input  logic [WIDTH-1:0]    PC,
    input  logic                Ld,
    input  logic                save_req,
    input  logic                restore_req,
    input  logic                cwp_ld,
    input  logic [4:0]          cwp_in,
    input  logic [NWINDOWS-1:0] wim,
    output logic [CWPW-1:0]     cwp,
    output logic                wof_trap,
    output logic                wuf_trap,
    output logic                cwp_err
);

    localparam int NREG = 8 + 16 * NWINDOWS;
    localparam int PW   = $clog2(NREG);
    localparam logic [CWPW-1:0] LAST = CWPW'(NWINDOWS - 1);

    logic [WIDTH-1:0] regs [NREG];

    // Flat index: 0..7 globals, then 16 per window (outs then locals).
    // The ins of window w alias the outs of window w+1.
    function automatic logic [PW-1:0] phys(
        input logic [4:0]      a,
        input logic [CWPW-1:0] w
    );
        int wi;
        int idx;
        wi = int'(w);
        if (a[4:3] == 2'b11) begin
            wi  = (wi == NWINDOWS - 1) ? 0 : wi + 1;
            idx = 8 + 16 * wi + int'(a[2:0]);
        end else if (a[4:3] == 2'b00) begin
            idx = int'(a);
        end else begin
            idx = 16 * wi + int'(a);
        end
        return PW'(idx);
    endfunction

    logic [CWPW-1:0] save_n;
    logic [CWPW-1:0] rest_n;
    logic [CWPW-1:0] next_cwp;
    logic [CWPW-1:0] wr_win;
    logic            cwp_ok;
    logic            wof_d;
    logic            wuf_d;
    logic            err_d;
    logic            wr_en;
    logic [PW-1:0]   wr_idx;

    always_comb begin
        save_n   = (cwp == '0) ? LAST : cwp - 1'b1;
        rest_n   = (cwp == LAST) ? '0 : cwp + 1'b1;
        cwp_ok   = {1'b0, cwp_in} < 6'(NWINDOWS);
        next_cwp = cwp;
        wof_d    = 1'b0;
        wuf_d    = 1'b0;
        err_d    = 1'b0;
        if (cwp_ld) begin
            if (cwp_ok) next_cwp = cwp_in[CWPW-1:0];
            else        err_d    = 1'b1;
        end else if (save_req) begin
            if (wim[save_n]) wof_d    = 1'b1;
            else             next_cwp = save_n;
        end else if (restore_req) begin
            if (wim[rest_n]) wuf_d    = 1'b1;
            else             next_cwp = rest_n;
        end
        // SAVE/RESTORE write rd in the new window; WRPSR does not.
        wr_win = cwp_ld ? cwp : next_cwp;
        wr_idx = phys(SC, wr_win);
        wr_en  = Ld && (SC != 5'd0) && !(wof_d || wuf_d || err_d);
    end

    always_comb begin
        PA = regs[phys(SA, cwp)];
        PB = regs[phys(SB, cwp)];
`ifdef RF_BYPASS_EN
        if (wr_en && (wr_idx == phys(SA, cwp))) PA = PC;
        if (wr_en && (wr_idx == phys(SB, cwp))) PB = PC;
`endif
        if (SA == 5'd0) PA = '0;
        if (SB == 5'd0) PB = '0;
    end

    // Storage shares the reset block so an edge under reset writes nothing.
    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            cwp      <= '0;
            wof_trap <= 1'b0;
            wuf_trap <= 1'b0;
            cwp_err  <= 1'b0;
        end else begin
            cwp      <= next_cwp;
            wof_trap <= wof_d;
            wuf_trap <= wuf_d;
            cwp_err  <= err_d;
            if (wr_en) regs[wr_idx] <= PC;
        end
    end

endmodule
